// File: rtl/mod_pkg.sv
// Shared definitions for the modulation/demodulation blocks:
// FSM state encoding, sample width and the default bit-one offset,
// plus the helper that forms one segment sample from phase and bit.
package mod_pkg;

  localparam int unsigned SEG_W  = 32;
  localparam int unsigned DATA_W = 32;

  // Offset that marks a 1 bit; the demodulators use the same value.
  localparam logic [SEG_W-1:0] OFFSET_ONE_DEFAULT = 32'd65536;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Segment sample: running phase plus the offset for a 1 bit, wrapping mod 2^SEG_W.
  function automatic logic [SEG_W-1:0] seg_sample(input logic [SEG_W-1:0] phase,
                                                   input logic             bit_v,
                                                   input logic [SEG_W-1:0] offset);
    return phase + (bit_v ? offset : '0);
  endfunction

endpackage

// File: rtl/modulation_segment_gen_if.sv
// Handshake bundle for modulation_segment_gen.
//   data_in/data_valid/data_ready          : word input, valid/ready
//   segment_out/segment_valid/segment_ready: sample output, valid/ready
//   busy/done                              : status
// master = the side feeding words and consuming segments; slave = the generator.
interface modulation_segment_gen_if;
  import mod_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic [SEG_W-1:0]  segment_out;
  logic              segment_valid;
  logic              segment_ready;
  logic              busy;
  logic              done;

  modport master (
    output data_in, data_valid, segment_ready,
    input  data_ready, segment_out, segment_valid, busy, done
  );

  modport slave (
    input  data_in, data_valid, segment_ready,
    output data_ready, segment_out, segment_valid, busy, done
  );

endinterface

// File: rtl/modulation_phase_acc.sv
// Running carrier phase: advances by PHASE_STEP on every accepted segment,
// wraps silently, cleared only by reset.
//   clk, reset     : clock, synchronous active-high reset
//   advance_i      : step the phase this cycle
//   phase_o        : current phase (registered)
//   phase_next_c   : phase after the next advance (combinational)
module modulation_phase_acc
  import mod_pkg::*;
#(
  parameter logic [SEG_W-1:0] PHASE_STEP = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  output logic [SEG_W-1:0] phase_o,
  output logic [SEG_W-1:0] phase_next_c
);

  logic [SEG_W-1:0] phase_q;
  logic [SEG_W-1:0] phase_d;

  assign phase_next_c = phase_q + PHASE_STEP;

  always_comb begin
    phase_d = phase_q;
    if (advance_i) phase_d = phase_next_c;
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/modulation_segment_gen.sv
// Serialises 32-bit words LSB-first and emits SYMBOL_LEN segment samples per
// bit; each sample is the running phase plus OFFSET_ONE for a 1 bit.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of modulation_segment_gen_if
//                (word in via data_*, samples out via segment_*, busy/done status)
module modulation_segment_gen
  import mod_pkg::*;
#(
  parameter int unsigned      SYMBOL_LEN = 4,
  parameter logic [SEG_W-1:0] OFFSET_ONE = OFFSET_ONE_DEFAULT,
  parameter logic [SEG_W-1:0] PHASE_STEP = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  modulation_segment_gen_if.slave bus
);

  localparam int unsigned CNT_W = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_e            state_q,      state_d;
  logic [DATA_W-1:0] shreg_q,      shreg_d;
  logic [BIT_W-1:0]  bit_idx_q,    bit_idx_d;
  logic [CNT_W-1:0]  sym_cnt_q,    sym_cnt_d;
  logic              data_ready_q, data_ready_d;
  logic [SEG_W-1:0]  seg_out_q,    seg_out_d;
  logic              seg_valid_q,  seg_valid_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;

  logic [SEG_W-1:0]  phase;
  logic [SEG_W-1:0]  phase_next_c;
  logic              accept_c;
  logic              xfer_c;
  logic              sym_wrap_c;
  logic              last_c;

  assign accept_c   = (state_q == IDLE) && data_ready_q && bus.data_valid;
  assign xfer_c     = (state_q == SEND) && seg_valid_q && bus.segment_ready;
  assign sym_wrap_c = (sym_cnt_q == SYM_LAST);
  assign last_c     = xfer_c && sym_wrap_c && (bit_idx_q == BIT_LAST);

  // Phase advances on every accepted segment, including the last of a word.
  modulation_phase_acc #(
    .PHASE_STEP (PHASE_STEP)
  ) u_phase (
    .clk          (clk),
    .reset        (reset),
    .advance_i    (xfer_c),
    .phase_o      (phase),
    .phase_next_c (phase_next_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    sym_cnt_d    = sym_cnt_q;
    data_ready_d = data_ready_q;
    seg_out_d    = seg_out_q;
    seg_valid_d  = seg_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        data_ready_d = 1'b1;
        if (accept_c) begin
          shreg_d      = bus.data_in;
          bit_idx_d    = '0;
          sym_cnt_d    = '0;
          data_ready_d = 1'b0;
          seg_out_d    = seg_sample(phase, bus.data_in[0], OFFSET_ONE);
          seg_valid_d  = 1'b1;
          busy_d       = 1'b1;
          state_d      = SEND;
        end
      end

      SEND: begin
        if (last_c) begin
          seg_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (xfer_c) begin
          // Next sample is built from the post-advance phase so transfers run back to back.
          if (sym_wrap_c) begin
            sym_cnt_d = '0;
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + BIT_W'(1);
            seg_out_d = seg_sample(phase_next_c, shreg_q[1], OFFSET_ONE);
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            seg_out_d = seg_sample(phase_next_c, shreg_q[0], OFFSET_ONE);
          end
        end
      end

      DONE: begin
        data_ready_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      sym_cnt_q    <= '0;
      data_ready_q <= 1'b0;
      seg_out_q    <= '0;
      seg_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      sym_cnt_q    <= sym_cnt_d;
      data_ready_q <= data_ready_d;
      seg_out_q    <= seg_out_d;
      seg_valid_q  <= seg_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.data_ready    = data_ready_q;
  assign bus.segment_out   = seg_out_q;
  assign bus.segment_valid = seg_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_modulation_segment_gen.sv
// Bench for modulation_segment_gen: three instances (PHASE_STEP 0, 16,
// 0x40000000) share one stimulus stream and run in lockstep; a scoreboard
// queue of expected sample triples is filled on each word accept and drained
// on each segment transfer.
module tb_modulation_segment_gen;

  localparam int unsigned NDUT    = 3;
  localparam int unsigned SYM     = 4;
  localparam int unsigned NSEG    = 32 * SYM;
  localparam logic [31:0] OFF_ONE = 32'h0001_0000;
  localparam logic [NDUT-1:0][31:0] STEPS = {32'h4000_0000, 32'd16, 32'd0};

  typedef logic [NDUT-1:0][31:0] trip_t;

  typedef struct {
    logic [31:0] data;
    bit          stall;
    bit          hold_dv;
    int unsigned exp_segs;
    int unsigned exp_lat;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        data_valid;
  logic        segment_ready;

  logic [31:0] seg_out   [NDUT];
  logic        seg_valid [NDUT];
  logic        dready    [NDUT];
  logic        busy_v    [NDUT];
  logic        done_v    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    modulation_segment_gen_if u_if ();
    assign u_if.data_in       = data_in;
    assign u_if.data_valid    = data_valid;
    assign u_if.segment_ready = segment_ready;
    assign seg_out[g]   = u_if.segment_out;
    assign seg_valid[g] = u_if.segment_valid;
    assign dready[g]    = u_if.data_ready;
    assign busy_v[g]    = u_if.busy;
    assign done_v[g]    = u_if.done;

    modulation_segment_gen #(
      .SYMBOL_LEN (SYM),
      .OFFSET_ONE (OFF_ONE),
      .PHASE_STEP (STEPS[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  trip_t       exp_q[$];
  trip_t       mph;
  trip_t       prev_seg;
  bit          prev_stall;
  bit          accepted;
  int unsigned cyc, acc_cyc, done_cyc;
  int unsigned xfers, stalls, done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected samples for one word, continuing each instance's model phase.
  task automatic push_word(input logic [31:0] w);
    trip_t t;
    logic  b;
    for (int s = 0; s < NSEG; s++) begin
      b = w[s / SYM];
      for (int d = 0; d < NDUT; d++) begin
        t[d]   = mph[d] + (b ? OFF_ONE : 32'd0);
        mph[d] = mph[d] + STEPS[d];
      end
      exp_q.push_back(t);
    end
  endtask

  // One clock: observe on the falling edge, then return just after the rising edge.
  task automatic step();
    trip_t e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      exp_q.delete();
      mph        = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        for (int d = 0; d < NDUT; d++) chk($sformatf("stall_hold[%0d]", d), seg_out[d], prev_seg[d]);
      if (data_valid && dready[0]) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        push_word(data_in);
      end
      if (seg_valid[0] && segment_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got transfer with value 0x%08h, required none", seg_out[0]);
        end else begin
          e = exp_q.pop_front();
          for (int d = 0; d < NDUT; d++) chk($sformatf("segment[%0d]", d), seg_out[d], e[d]);
        end
      end
      if (seg_valid[0] && !segment_ready) stalls++;
      if (done_v[0]) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_done", 32'(busy_v[0]), 32'd1);
        chk("ready_low_in_done", 32'(dready[0]), 32'd0);
      end
      prev_stall = seg_valid[0] && !segment_ready;
      for (int d = 0; d < NDUT; d++) prev_seg[d] = seg_out[d];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      step();
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, required accept within 20 cycles");
    end
  endtask

  task automatic send_word(input vec_t v);
    int n = 0;
    data_in       = v.data;
    data_valid    = 1'b1;
    segment_ready = 1'b1;
    wait_accept();
    if (v.hold_dv) data_in = 32'hDEAD_BEEF;
    else           data_valid = 1'b0;
    xfers    = 0;
    stalls   = 0;
    done_cnt = 0;
    while (done_cnt == 0 && n < 3000) begin
      segment_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      n++;
    end
    data_valid    = 1'b0;
    segment_ready = 1'b1;
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("done_latency", done_cyc - acc_cyc, v.exp_lat + stalls);
    chk("seg_count", xfers, v.exp_segs);
    step();
    chk("done_single", 32'(done_cnt), 32'd1);
    chk("data_ready_back", 32'(dready[0]), 32'd1);
    chk("busy_idle", 32'(busy_v[0]), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 32'h0000_0005, stall: 1'b0, hold_dv: 1'b0, exp_segs: NSEG, exp_lat: NSEG + 1};
    vecs[1] = '{data: 32'hFFFF_FFFF, stall: 1'b0, hold_dv: 1'b0, exp_segs: NSEG, exp_lat: NSEG + 1};
    vecs[2] = '{data: 32'hFFFF_FFFF, stall: 1'b1, hold_dv: 1'b0, exp_segs: NSEG, exp_lat: NSEG + 1};
    vecs[3] = '{data: 32'hA5A5_3C0F, stall: 1'b1, hold_dv: 1'b1, exp_segs: NSEG, exp_lat: NSEG + 1};
    vecs[4] = '{data: 32'h0000_0000, stall: 1'b0, hold_dv: 1'b1, exp_segs: NSEG, exp_lat: NSEG + 1};
    vecs[5] = '{data: 32'h8000_0001, stall: 1'b1, hold_dv: 1'b0, exp_segs: NSEG, exp_lat: NSEG + 1};

    reset         = 1'b1;
    data_in       = '0;
    data_valid    = 1'b0;
    segment_ready = 1'b0;
    mph           = '0;
    prev_seg      = '0;
    prev_stall    = 1'b0;
    cyc           = 0;
    acc_cyc       = 0;
    done_cyc      = 0;

    // Reset values, then data_ready one edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_seg_out[%0d]", d), seg_out[d], 32'd0);
      chk($sformatf("rst_seg_valid[%0d]", d), 32'(seg_valid[d]), 32'd0);
      chk($sformatf("rst_ready[%0d]", d), 32'(dready[d]), 32'd0);
      chk($sformatf("rst_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("rst_done[%0d]", d), 32'(done_v[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_after_release", 32'(dready[0]), 32'd1);
    @(posedge clk);
    #1;
    segment_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_valid_low", 32'(seg_valid[0]), 32'd0);
      chk("idle_busy_low", 32'(busy_v[0]), 32'd0);
    end

    for (int i = 0; i < 6; i++) send_word(vecs[i]);

    // Abort mid-word after 50 segments.
    data_in       = 32'h0000_00F3;
    data_valid    = 1'b1;
    segment_ready = 1'b1;
    wait_accept();
    data_valid = 1'b0;
    xfers      = 0;
    done_cnt   = 0;
    for (int n = 0; n < 500 && xfers < 50; n++) step();
    chk("abort_xfers", xfers, 32'd50);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("abort_valid[%0d]", d), 32'(seg_valid[d]), 32'd0);
      chk($sformatf("abort_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("abort_out[%0d]", d), seg_out[d], 32'd0);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    step();
    chk("abort_ready_back", 32'(dready[0]), 32'd1);

    // Fresh word after abort starts from phase 0.
    send_word('{data: 32'h0000_0005, stall: 1'b0, hold_dv: 1'b0, exp_segs: NSEG, exp_lat: NSEG + 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulation_segment_gen.md
# modulation_segment_gen

Transmit-side counterpart to the unrolled demodulation blocks: accepts 32-bit data words over a valid/ready handshake, serialises them LSB-first, and emits for each bit SYMBOL_LEN 32-bit segment samples whose value encodes the bit as a fixed offset on a running phase. Its output stream is shaped so that the demodulation blocks recover the original bits. A valid/ready handshake on the segment side supports backpressure.

## Interface
Parameters:
- SYMBOL_LEN, 4: segments emitted per data bit; legal range 1..256.
- OFFSET_ONE, 65536: value added to the phase for a 1 bit; a 0 bit adds 0.
- PHASE_STEP, 0: phase increment applied per accepted segment.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  32  word to transmit; sampled on the accept cycle.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  registered; high only in IDLE.
- segment_out  out  32  registered segment sample.
- segment_valid  out  1  registered; segment_out is valid.
- segment_ready  in  1  downstream accepts the segment.
- busy  out  1  high in SEND and DONE.
- done  out  1  one-cycle pulse after the last segment of a word is accepted.

## Operation
- The one clock is clk. Reset is synchronous and active-high on reset.
- Every register resets to 0 in the cycle reset is sampled high: state=IDLE, data_ready=0, segment_out=0, segment_valid=0, busy=0, done=0, phase=0, bit_idx=0, sym_cnt=0.
- data_ready rises on the first cycle after reset is released.
- The FSM has three states: IDLE, SEND, DONE.
- IDLE: data_ready=1. On data_valid&&data_ready, the block latches data_in into shreg, clears bit_idx and sym_cnt, drops data_ready, and moves to SEND.
- SEND: segment_out = phase + (shreg[0] ? OFFSET_ONE : 0), modulo 2^32.
  - segment_valid stays high; segment_out is held stable while segment_ready=0.
  - On each segment_valid&&segment_ready: phase += PHASE_STEP, modulo 2^32 with silent wrap, and sym_cnt increments.
  - When sym_cnt wraps at SYMBOL_LEN-1, shreg shifts right 1 and bit_idx increments.
  - The next segment_out is registered in the same cycle, so back-to-back transfers run at full rate.
  - After accepting segment number 32*SYMBOL_LEN, segment_valid drops and the FSM moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE with data_ready=1.
- phase is not cleared between words; it is cleared only by reset, giving a continuous carrier.
- data_valid outside IDLE is ignored; the word is not consumed.
- Reset mid-word aborts immediately. There is no done pulse, the partial word is dropped, and outputs take their reset values in the next cycle.
- segment_ready while segment_valid=0 has no effect.

## Timing
- Accept at cycle T: first segment valid at T+1.
- With segment_ready held high: last segment accepted at T+32*SYMBOL_LEN, done at T+32*SYMBOL_LEN+1, data_ready at T+32*SYMBOL_LEN+2.
- Word-to-word throughput is 32*SYMBOL_LEN+2 cycles minimum.
- Each cycle of segment_ready=0 during SEND adds one cycle of latency.
- The accept cycle and the done cycle never overlap, because data_ready is low in DONE.

## Structure
- Shared package mod_pkg holds:
  - the state enum (IDLE, SEND, DONE);
  - the default OFFSET_ONE=65536 constant, shared with the demodulation blocks;
  - a SEG_W=32 width constant.
- One natural sub-module, modulation_phase_acc: the 32-bit phase register with synchronous reset, an advance enable, and the PHASE_STEP increment.
- The FSM, shift register and counters stay in the top module.

## Test plan
- Reset, defaults (SYMBOL_LEN=4, PHASE_STEP=0): all outputs 0 during reset; data_ready=1 on the first cycle after release; segment_valid stays 0 with data_valid low.
- data_in=0x00000005, segment_ready=1: segments 0-3=65536, 4-7=0, 8-11=65536, then 116 segments of 0. done pulses exactly once at accept+129; data_ready returns at accept+130.
- PHASE_STEP=16, data_in=0xFFFFFFFF: segment k = 16*k + 65536. Phase continues from 16*128=2048 on the next word.
- PHASE_STEP=0x40000000: phase wraps 0xC0000000 -> 0x00000000 with no error; segment_out equals phase+OFFSET_ONE modulo 2^32.
- Random segment_ready stall pattern: segment_out stays stable across stalls; exactly 128 segments are transferred; the sequence is identical to the unstalled run.
- Reset asserted after 50 segments: next cycle segment_valid=0, no done pulse, phase=0. A new word then starts from sample 0.
